sseg_score_display: RTL

- Downstream consumer of the game score (tail count) produced by the game logic.
- Converts the binary score to four BCD digits with a sequential double-dabble engine.
- Time-multiplexes those digits onto the board's 4-digit 7-segment display, driving the sseg_a_to_dp / sseg_an top-level pins.
- Runs on sys_clk (50 MHz), independent of the VGA clock domain. The score input is treated as quasi-static; it changes only at game-update ticks.

---
 rtl/sseg_pkg.sv | 46 ++++
 rtl/bin2bcd_seq.sv | 124 ++++++++++++
 rtl/sseg_score_display.sv | 88 ++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// Shared constants and types for the score display: canonical active-high
// 7-segment patterns (bit0 = a ... bit6 = g), the display ceiling and digit index.
package sseg_pkg;

  localparam int MAX_DISPLAY = 9999;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } conv_state_t;

  // Non-decimal nibbles cannot come out of the converter; they map to blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle, saturating at
// MAX_DISPLAY, with the finished BCD value held until the next conversion.
//
//   state    | meaning
//   ST_IDLE  | waiting for a score change or the post-reset force flag
//   ST_SHIFT | adjust-and-shift, one binary bit per cycle, SCORE_W cycles
//   ST_LOAD  | publish accumulator to bcd_o and pulse done_o
module bin2bcd_seq
  import sseg_pkg::*;
#(
  parameter int SCORE_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [SCORE_W-1:0] score_i,
  output logic [15:0]        bcd_o,
  output logic               done_o
);

  localparam int CNT_W = $clog2(SCORE_W) + 1;

  conv_state_t        state_q, state_d;
  logic [SCORE_W-1:0] bin_q, bin_d;
  logic [SCORE_W-1:0] last_q, last_d;
  logic [SCORE_W-1:0] sat_score;
  logic [15:0]        acc_q, acc_d, acc_adj;
  logic [15:0]        bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               force_q, force_d;
  logic               done_q, done_d;
  logic               conv_req;
  logic               start, shift_en, load_en;

  assign conv_req = (score_i != last_q) || force_q;

  always_comb begin
    if (32'(score_i) > 32'(MAX_DISPLAY)) sat_score = SCORE_W'(MAX_DISPLAY);
    else                                 sat_score = score_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (conv_req) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == CNT_W'(SCORE_W - 1)) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start    = 1'b0;
    shift_en = 1'b0;
    load_en  = 1'b0;
    case (state_q)
      ST_IDLE:  start    = conv_req;
      ST_SHIFT: shift_en = 1'b1;
      ST_LOAD:  load_en  = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 4; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    bin_d   = bin_q;
    last_d  = last_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    force_d = force_q;
    done_d  = 1'b0;
    if (start) begin
      bin_d   = sat_score;
      last_d  = score_i;
      force_d = 1'b0;
      cnt_d   = '0;
      acc_d   = '0;
    end
    if (shift_en) begin
      acc_d = {acc_adj[14:0], bin_q[SCORE_W-1]};
      bin_d = bin_q << 1;
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (load_en) begin
      bcd_d  = acc_q;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bin_q   <= '0;
      last_q  <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      force_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      force_q <= force_d;
      done_q  <= done_d;
    end
  end

  assign bcd_o  = bcd_q;
  assign done_o = done_q;

endmodule

// File: rtl/sseg_score_display.sv
// Four-digit multiplexed 7-segment score display: BCD conversion, refresh
// scan, leading-zero blanking and registered, polarity-adjusted pin drive.
module sseg_score_display
  import sseg_pkg::*;
#(
  parameter int SCORE_W        = 8,
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int BLANK_LZ       = 1
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic [SCORE_W-1:0] score,
  output logic [7:0]         sseg_a_to_dp,
  output logic [3:0]         sseg_an,
  output logic               conv_done
);

  localparam int RCNT_W = $clog2(REFRESH_DIV);
  // XOR masks: the "all off" pin level doubles as the polarity inverter.
  localparam logic [7:0] SEG_MASK = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [3:0] AN_MASK  = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  logic [15:0]       disp;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  digit_idx_t        scan_q, scan_d;
  logic [7:0]        seg_q, seg_d;
  logic [3:0]        an_q, an_d;
  logic [3:0]        nib;
  logic [6:0]        seg_hi;
  logic              blank;

  bin2bcd_seq #(
    .SCORE_W (SCORE_W)
  ) u_bin2bcd (
    .clk_i   (sys_clk),
    .rst_i   (reset),
    .score_i (score),
    .bcd_o   (disp),
    .done_o  (conv_done)
  );

  always_comb begin
    rcnt_d = rcnt_q + RCNT_W'(1);
    scan_d = scan_q;
    if (rcnt_q == RCNT_W'(REFRESH_DIV - 1)) begin
      rcnt_d = '0;
      scan_d = scan_q + 2'd1;
    end
  end

  always_comb begin
    blank = 1'b0;
    case (scan_q)
      2'd1:    blank = (disp[15:4] == 12'd0);
      2'd2:    blank = (disp[15:8] == 8'd0);
      2'd3:    blank = (disp[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
    if (BLANK_LZ == 0) blank = 1'b0;
  end

  always_comb begin
    nib    = disp[{scan_q, 2'b00} +: 4];
    seg_hi = blank ? SEG_BLANK : seg_decode(nib);
    seg_d  = {1'b0, seg_hi} ^ SEG_MASK;
    an_d   = (4'b0001 << scan_q) ^ AN_MASK;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      rcnt_q <= '0;
      scan_q <= '0;
      seg_q  <= SEG_MASK;
      an_q   <= AN_MASK;
    end else begin
      rcnt_q <= rcnt_d;
      scan_q <= scan_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  assign sseg_a_to_dp = seg_q;
  assign sseg_an      = an_q;

endmodule
